// File: rtl/ppi_pkg.sv
// Shared constants and types for the 8255A-compatible PPI group A logic.
// PC bit positions index the PC7..PC3 vector (index = pin number - 3).
package ppi_pkg;

    localparam logic [1:0] ADDR_PA = 2'd0;
    localparam logic [1:0] ADDR_PC = 2'd2;
    localparam logic [1:0] ADDR_CW = 2'd3;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;

    localparam logic [2:0] INTR_A     = 3'd0;
    localparam logic [2:0] STB_A      = 3'd1;
    localparam logic [2:0] IBF_A      = 3'd2;
    localparam logic [2:0] ACK_A      = 3'd3;
    localparam logic [2:0] OBF_A      = 3'd4;
    localparam logic [2:0] INTE_IN_A  = 3'd1;
    localparam logic [2:0] INTE_OUT_A = 3'd3;

    localparam logic [4:0] PC_IDLE = 5'b10000;

    typedef enum logic [2:0] {
        HS_IDLE,
        IN_EMPTY,
        IN_FULL,
        OUT_EMPTY,
        OUT_FULL
    } hs_state_t;

    // Mode codes 1x collapse onto mode 1; group A has no mode 2 here.
    function automatic logic [1:0] norm_mode(input logic [1:0] code);
        return (code == 2'b00) ? MODE_0 : MODE_1;
    endfunction

    function automatic hs_state_t hs_entry_state(input logic [1:0] mode, input logic dir_in);
        if (mode == MODE_1)
            return dir_in ? IN_EMPTY : OUT_EMPTY;
        return HS_IDLE;
    endfunction

endpackage

// File: rtl/ppi_sync_edge.sv
// Two-flop synchronizer for an asynchronous handshake pin, plus a third
// flop that turns the synchronized level into single-cycle rise/fall pulses.
module ppi_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/ppi_group_a_ctrl.sv
// Group A control for the PPI: CPU register decode, mode/direction config,
// mode 1 strobed input/output handshakes on PC7..PC3 and output enables.
module ppi_group_a_ctrl
    import ppi_pkg::*;
#(
    parameter logic [1:0] RESET_MODE = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] a,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    input  logic [4:0] pc_in,
    input  logic [2:0] pc_lo_in,
    output logic [4:0] pc_out,
    output logic [4:0] pc_oe
);

    logic [1:0] mode;
    logic       dir_a;
    logic       dir_cu;
    logic [7:0] pa_latch;
    logic [4:0] pc_lat;
    logic       inte;
    logic       intr;
    logic       clr_pend;
    logic       wr_prev;
    logic       rd_prev;
    hs_state_t  state;
    hs_state_t  state_nxt;

    logic stb_rise, stb_fall, ack_rise, ack_fall;

    ppi_sync_edge #(.RESET_VAL(1'b1)) u_sync_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pc_in[STB_A]),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    ppi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pc_in[ACK_A]),
        .rise  (ack_rise),
        .fall  (ack_fall)
    );

    logic wr_fire, rd_fire;
    logic mode_set, bsr, pa_wr, pc_wr, pa_rd;
    logic in_hs, out_hs;
    logic stb_fall_hs, stb_rise_hs, ack_fall_hs, ack_rise_hs;
    logic [2:0] bsr_idx;
    logic [2:0] inte_idx;
    logic       bsr_valid;

    // An access fires on the first edge that sees its strobe low.
    assign wr_fire  = !cs_n && !wr_n && wr_prev;
    assign rd_fire  = !cs_n && !rd_n && rd_prev;
    assign mode_set = wr_fire && (a == ADDR_CW) && d_in[7];
    assign bsr      = wr_fire && (a == ADDR_CW) && !d_in[7];
    assign pa_wr    = wr_fire && (a == ADDR_PA);
    assign pc_wr    = wr_fire && (a == ADDR_PC);
    assign pa_rd    = rd_fire && (a == ADDR_PA);

    assign in_hs  = (state == IN_EMPTY) || (state == IN_FULL);
    assign out_hs = (state == OUT_EMPTY) || (state == OUT_FULL);

    assign stb_fall_hs = stb_fall && in_hs;
    assign stb_rise_hs = stb_rise && in_hs;
    assign ack_fall_hs = ack_fall && out_hs;
    assign ack_rise_hs = ack_rise && out_hs;

    assign bsr_valid = (d_in[3:1] >= 3'd3);
    assign bsr_idx   = d_in[3:1] - 3'd3;
    assign inte_idx  = in_hs ? INTE_IN_A : INTE_OUT_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= hs_entry_state(norm_mode(RESET_MODE), 1'b1);
        else
            state <= state_nxt;
    end

    // A strobe edge beats a pending IBF clear; a CPU write beats ACK_n.
    always_comb begin
        state_nxt = state;
        if (mode_set) begin
            state_nxt = hs_entry_state(norm_mode(d_in[6:5]), d_in[4]);
        end else begin
            case (state)
                IN_EMPTY:  if (stb_fall_hs) state_nxt = IN_FULL;
                IN_FULL:   if (!stb_fall_hs && clr_pend) state_nxt = IN_EMPTY;
                OUT_EMPTY: if (pa_wr) state_nxt = OUT_FULL;
                OUT_FULL:  if (!pa_wr && ack_fall_hs) state_nxt = OUT_EMPTY;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= norm_mode(RESET_MODE);
            dir_a    <= 1'b1;
            dir_cu   <= 1'b1;
            pa_out   <= 8'h00;
            pa_latch <= 8'h00;
            pc_lat   <= PC_IDLE;
            inte     <= 1'b0;
            intr     <= 1'b0;
            clr_pend <= 1'b0;
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
        end else begin
            wr_prev  <= wr_n;
            rd_prev  <= rd_n;
            clr_pend <= 1'b0;
            if (mode_set) begin
                mode   <= norm_mode(d_in[6:5]);
                dir_a  <= d_in[4];
                dir_cu <= d_in[3];
                pa_out <= 8'h00;
                pc_lat <= PC_IDLE;
                inte   <= 1'b0;
                intr   <= 1'b0;
            end else begin
                if (bsr && bsr_valid) begin
                    if (mode == MODE_1 && bsr_idx == inte_idx)
                        inte <= d_in[0];
                    else
                        pc_lat[bsr_idx] <= d_in[0];
                end
                if (pc_wr)
                    pc_lat <= d_in[7:3];
                if (pa_wr)
                    pa_out <= d_in;
                if (stb_fall_hs)
                    pa_latch <= pa_in;
                if (pa_rd && state == IN_FULL && !stb_fall_hs)
                    clr_pend <= 1'b1;
                if (stb_rise_hs && state == IN_FULL && inte)
                    intr <= 1'b1;
                if (ack_rise_hs && inte)
                    intr <= 1'b1;
                if ((in_hs && pa_rd) || (out_hs && pa_wr))
                    intr <= 1'b0;
            end
        end
    end

    logic       ibf;
    logic       obf_n;
    logic [3:0] gp_rd;
    logic [4:0] pc_rd;
    logic [7:0] pa_rd_val;

    assign ibf   = (state == IN_FULL);
    assign obf_n = (state != OUT_FULL);
    assign pa_oe = ~dir_a;
    assign gp_rd = dir_cu ? pc_in[4:1] : pc_lat[4:1];

    always_comb begin
        pc_out = pc_lat;
        pc_oe  = {{4{~dir_cu}}, 1'b0};
        pc_rd  = {gp_rd, pc_in[0]};
        if (in_hs) begin
            pc_out = {pc_lat[4:3], ibf, 1'b0, intr};
            pc_oe  = {~dir_cu, ~dir_cu, 1'b1, 1'b0, 1'b1};
            pc_rd  = {gp_rd[3:2], ibf, inte, intr};
        end else if (out_hs) begin
            pc_out = {obf_n, 1'b0, pc_lat[2:1], intr};
            pc_oe  = {1'b1, 1'b0, ~dir_cu, ~dir_cu, 1'b1};
            pc_rd  = {obf_n, inte, gp_rd[1:0], intr};
        end
    end

    always_comb begin
        pa_rd_val = pa_out;
        if (in_hs)
            pa_rd_val = pa_latch;
        else if (dir_a)
            pa_rd_val = pa_in;
    end

    always_comb begin
        d_out = 8'h00;
        if (!cs_n && !rd_n) begin
            case (a)
                ADDR_PA: d_out = pa_rd_val;
                ADDR_PC: d_out = {pc_rd, pc_lo_in};
                default: d_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_group_a_ctrl.sv
// Directed bench for ppi_group_a_ctrl: mode 0 access, mode 1 input/output
// handshakes, same-cycle collisions and asynchronous reset.
module tb_ppi_group_a_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] a;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic [4:0] pc_in;
    logic [2:0] pc_lo_in;
    logic [4:0] pc_out;
    logic [4:0] pc_oe;

    int n_checks = 0;
    int n_fail   = 0;

    ppi_group_a_ctrl #(.RESET_MODE(2'b00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .a        (a),
        .d_in     (d_in),
        .d_out    (d_out),
        .pa_in    (pa_in),
        .pa_out   (pa_out),
        .pa_oe    (pa_oe),
        .pc_in    (pc_in),
        .pc_lo_in (pc_lo_in),
        .pc_out   (pc_out),
        .pc_oe    (pc_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] data);
        a    = addr;
        d_in = data;
        cs_n = 1'b0;
        wr_n = 1'b0;
        tick();
        cs_n = 1'b1;
        wr_n = 1'b1;
        tick();
    endtask

    task automatic rd_begin(input logic [1:0] addr);
        a    = addr;
        cs_n = 1'b0;
        rd_n = 1'b0;
        #1;
    endtask

    task automatic rd_end();
        cs_n = 1'b1;
        rd_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        a        = 2'd0;
        d_in     = 8'h00;
        pa_in    = 8'h00;
        pc_in    = 5'b01010;
        pc_lo_in = 3'b101;

        #12;
        check_eq("rst_pa_out", 32'(pa_out), 32'h00);
        check_eq("rst_pc_out", 32'(pc_out), 32'h10);
        check_eq("rst_pc_oe",  32'(pc_oe),  32'h00);
        check_eq("rst_pa_oe",  32'(pa_oe),  32'h0);
        check_eq("rst_d_out",  32'(d_out),  32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Mode 0, A out, CU out
        cpu_wr(2'd3, 8'h80);
        cpu_wr(2'd0, 8'h5A);
        check_eq("m0_pa_out", 32'(pa_out), 32'h5A);
        check_eq("m0_pa_oe",  32'(pa_oe),  32'h1);
        check_eq("m0_pc_oe",  32'(pc_oe),  32'h1E);

        cpu_wr(2'd3, 8'h0E);
        check_eq("bsr_pc7_clr", 32'(pc_out), 32'h00);
        cpu_wr(2'd3, 8'h0F);
        check_eq("bsr_pc7_set", 32'(pc_out), 32'h10);
        cpu_wr(2'd3, 8'h03);
        check_eq("bsr_low_ignored", 32'(pc_out), 32'h10);
        rd_begin(2'd2);
        check_eq("m0_rd_pc_latch", 32'(d_out), 32'h85);
        tick();
        rd_end();
        tick();
        cpu_wr(2'd3, 8'h0E);
        check_eq("bsr_pc7_clr2", 32'(pc_out), 32'h00);

        // Mode 0, A out, CU in: Port C read reflects pins
        cpu_wr(2'd3, 8'h88);
        check_eq("m0_cu_in_oe", 32'(pc_oe), 32'h00);
        rd_begin(2'd2);
        check_eq("m0_rd_pc_pins", 32'(d_out), 32'h55);
        tick();
        rd_end();
        tick();

        // Mode 1 strobed input
        cpu_wr(2'd3, 8'hB0);
        cpu_wr(2'd3, 8'h09);
        check_eq("m1i_pc_oe", 32'(pc_oe), 32'h1D);
        check_eq("m1i_pa_oe", 32'(pa_oe), 32'h0);
        pa_in    = 8'hC3;
        pc_in[1] = 1'b0;
        tick();
        tick();
        check_eq("m1i_ibf_n1", 32'(pc_out[2]), 32'h0);
        tick();
        check_eq("m1i_ibf_n2", 32'(pc_out[2]), 32'h1);
        pc_in[1] = 1'b1;
        tick();
        tick();
        check_eq("m1i_intr_m1", 32'(pc_out[0]), 32'h0);
        tick();
        check_eq("m1i_intr_m2", 32'(pc_out[0]), 32'h1);
        pa_in = 8'h3C;
        rd_begin(2'd0);
        check_eq("m1i_rd_data", 32'(d_out), 32'hC3);
        tick();
        check_eq("m1i_intr_rd", 32'(pc_out[0]), 32'h0);
        check_eq("m1i_ibf_rd",  32'(pc_out[2]), 32'h1);
        rd_end();
        tick();
        check_eq("m1i_ibf_clr", 32'(pc_out[2]), 32'h0);

        // STB_n fall on the same edge as a Port A read
        pa_in    = 8'h11;
        pc_in[1] = 1'b0;
        tick(); tick(); tick();
        pc_in[1] = 1'b1;
        tick(); tick(); tick();
        pa_in    = 8'h22;
        pc_in[1] = 1'b0;
        tick();
        tick();
        rd_begin(2'd0);
        check_eq("coll_rd_old", 32'(d_out), 32'h11);
        tick();
        check_eq("coll_ibf_edge", 32'(pc_out[2]), 32'h1);
        rd_end();
        tick();
        check_eq("coll_ibf_after", 32'(pc_out[2]), 32'h1);
        rd_begin(2'd0);
        check_eq("coll_rd_new", 32'(d_out), 32'h22);
        tick();
        rd_end();
        tick();
        pc_in[1] = 1'b1;
        tick(); tick(); tick();

        // Mode 1 strobed output
        cpu_wr(2'd3, 8'hA0);
        check_eq("m1o_pc_oe",  32'(pc_oe),  32'h17);
        check_eq("m1o_pc_out", 32'(pc_out), 32'h10);
        cpu_wr(2'd3, 8'h0D);
        cpu_wr(2'd0, 8'h77);
        check_eq("m1o_pa_out", 32'(pa_out), 32'h77);
        check_eq("m1o_obf_wr", 32'(pc_out[4]), 32'h0);
        check_eq("m1o_pa_oe",  32'(pa_oe), 32'h1);
        pc_in[3] = 1'b0;
        tick();
        tick();
        check_eq("m1o_obf_n1", 32'(pc_out[4]), 32'h0);
        tick();
        check_eq("m1o_obf_n2", 32'(pc_out[4]), 32'h1);
        pc_in[3] = 1'b1;
        tick();
        tick();
        check_eq("m1o_intr_m1", 32'(pc_out[0]), 32'h0);
        tick();
        check_eq("m1o_intr_m2", 32'(pc_out[0]), 32'h1);

        // ACK_n fall on the same edge as a Port A write
        pc_in[3] = 1'b0;
        tick();
        tick();
        a    = 2'd0;
        d_in = 8'h99;
        cs_n = 1'b0;
        wr_n = 1'b0;
        tick();
        check_eq("coll_obf_edge", 32'(pc_out[4]), 32'h0);
        check_eq("coll_pa_out",   32'(pa_out), 32'h99);
        check_eq("coll_intr",     32'(pc_out[0]), 32'h0);
        cs_n = 1'b1;
        wr_n = 1'b1;
        tick();
        check_eq("coll_obf_after", 32'(pc_out[4]), 32'h0);
        pc_in[3] = 1'b1;
        tick(); tick(); tick();

        // Mode code 1x is stored as mode 1; mode-set aborts the handshake
        cpu_wr(2'd3, 8'hC0);
        check_eq("m2_as_m1_oe",  32'(pc_oe),  32'h17);
        check_eq("m2_as_m1_out", 32'(pc_out), 32'h10);
        check_eq("m2_as_m1_pa",  32'(pa_out), 32'h00);
        cpu_wr(2'd0, 8'hAB);
        check_eq("full_pc_out", 32'(pc_out), 32'h00);

        // Asynchronous reset while OUT_FULL
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_pa_out", 32'(pa_out), 32'h00);
        check_eq("arst_pc_out", 32'(pc_out), 32'h10);
        check_eq("arst_pc_oe",  32'(pc_oe),  32'h00);
        check_eq("arst_pa_oe",  32'(pa_oe),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppi_group_a_ctrl.md
# ppi_group_a_ctrl

Group A control and handshake sequencer for the 8255A-compatible PPI. Decodes CPU accesses to the control word register, Port A and Port C, and holds the group A mode and direction configuration. Runs the mode 1 strobed-input and strobed-output handshakes on PC7..PC3 and drives the Port A / Port C-upper output enables. Sits between the CPU bus interface and the Port A / Port C pin logic.

## Interface
- `RESET_MODE`, default 2'b00: group A mode after reset (only 00 and 01 are legal).
- `clk` input 1: system clock; the CPU bus is synchronous to it.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cs_n` input 1: chip select, active-low.
- `rd_n` input 1: read strobe, active-low.
- `wr_n` input 1: write strobe, active-low.
- `a` input 2: register select: 0 = Port A, 2 = Port C, 3 = control word.
- `d_in` input 8: CPU write data.
- `d_out` output 8: CPU read data; combinational; 0 when not reading.
- `pa_in` input 8: Port A pins.
- `pa_out` output 8: Port A output latch.
- `pa_oe` output 1: Port A drive enable.
- `pc_in` input 5: pins PC7..PC3; asynchronous to `clk`.
- `pc_lo_in` input 3: pins PC2..PC0, read-only here.
- `pc_out` output 5: drive values for PC7..PC3.
- `pc_oe` output 5: per-bit drive enables for PC7..PC3.

## Operation
- Write access fires at the rising edge where `cs_n`=0, `wr_n`=0 and the registered `wr_n` is 1. Read access uses the same rule with `rd_n` and is used only for side effects.
- Mode-set write to a=3 with d[7]=1:
  - mode = d[6:5]; a value of 1x is stored as 01.
  - Port A direction = d[4] (1 = input).
  - PC-upper direction = d[3] (1 = input).
  - Clears `pa_out`, `pc_out`, INTE, IBF and INTR; sets OBF_n = 1.
  - Any handshake in progress is aborted.
- Bit set/reset write to a=3 with d[7]=0: PC bit d[3:1] takes value d[0]. In mode 1, a write to the INTE bit (PC4 for input, PC6 for output) updates INTE instead of the pin. Writes to bits 2..0 are ignored.
- Mode 0:
  - `pa_oe` = ~dirA.
  - `pc_oe[7:4]` = {4{~dirCU}}; `pc_oe[3]` = 0.
  - A read of Port C returns {PC7..PC4 = latch if output else pin, `pc_in[0]`, `pc_lo_in`}.
- Mode 1 input (dirA=1). States: IN_EMPTY, IN_FULL.
  - Pin roles: PC4 = STB_n (input), PC5 = IBF (output), PC3 = INTR (output).
  - STB_n falling edge: latch `pa_in`, IBF=1, go to IN_FULL.
  - STB_n rising edge with IBF=1 and INTE=1: INTR=1.
  - Port A read: INTR=0 when the read fires, IBF=0 one cycle later, return to IN_EMPTY.
  - A new STB_n falling edge in IN_FULL overwrites the latch.
- Mode 1 output (dirA=0). States: OUT_EMPTY, OUT_FULL.
  - Pin roles: PC7 = OBF_n (output), PC6 = ACK_n (input), PC3 = INTR (output).
  - `pa_oe` = 1 continuously.
  - Port A write: update `pa_out`, OBF_n=0, INTR=0, go to OUT_FULL.
  - ACK_n falling edge: OBF_n=1, go to OUT_EMPTY.
  - ACK_n rising edge with INTE=1: INTR=1.
- Mode 1 Port C read returns the status byte: {PC7..PC3 = OBF_n/ACK_n-pin/IBF/INTE-or-STB_n as per mode, INTR, `pc_lo_in`}.
- Simultaneous events:
  - STB_n fall and Port A read in the same cycle: the read returns the old latch, the new data is latched, IBF stays 1.
  - ACK_n fall and Port A write in the same cycle: the write wins, so OBF_n=0.

## Timing
- Reset values:
  - `pa_out`=0, `pc_out`=5'b10000 (OBF_n high), `pc_oe`=0, `pa_oe`=0.
  - mode=RESET_MODE, dirA=1, dirCU=1, INTE=0, IBF=0, INTR=0.
- CPU write: takes effect at the firing edge and is visible on the outputs immediately after it.
- PC inputs pass through a 2-flop synchronizer followed by an edge-detect flop. A pin change first sampled at edge N updates state at edge N+2.
- INTR is set no earlier than edge N+2 after the STB_n/ACK_n rising edge is first sampled.
- `rst_n` assertion mid-handshake clears all state asynchronously. Release is synchronized by the system.

## Structure
- `ppi_pkg`: register address constants, mode codes, PC bit-position constants (STB_A, IBF_A, INTR_A, ACK_A, OBF_A, INTE bits), and the handshake state enum.
- Sub-module `ppi_sync_edge`: 2-flop synchronizer plus rise/fall detect. Instantiated once each for PC4 and PC6.

## Test plan
- Reset, then mode-set 0x80 (mode 0, A out, CU out), write A=0x5A -> `pa_out`=0x5A, `pa_oe`=1, `pc_oe`=5'b11110.
- Mode-set 0xB0 (mode 1, A in), BSR 0x09 (INTE_A=1), pulse STB_n low with `pa_in`=0xC3 -> IBF=1 at N+2; after the rise INTR=1; read A returns 0xC3, INTR=0 on the read edge, IBF=0 next cycle.
- Mode-set 0xA0 (mode 1, A out), BSR 0x0D (INTE=1), write A=0x77 -> OBF_n=0; ACK_n low pulse -> OBF_n=1 at N+2; after the ACK_n rise INTR=1.
- BSR 0x0F, then 0x0E in mode 0 with CU out -> PC7 goes 1 then 0; bits 2..0 unaffected.
- STB_n fall in the same cycle as a Port A read -> read returns the old byte, new byte latched, IBF=1.
- Assert `rst_n` while in OUT_FULL -> all outputs return to reset values the same instant, with no clock required.
